// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: shadowed BCD word, per-digit blanking gap, dash for non-BCD codes.
// Outputs are registered, so they change one edge after the shadow does; define SEVSEG_LZB_EN for leading-zero blanking.
module sevenseg_scan_driver #(
   parameter int NDIG        = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GAP_CYC     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [4*NDIG-1:0] bcd,
   input  logic [NDIG-1:0]   dp_mask,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        seg,
   output logic              dp,
   output logic              frame_tick
);

   localparam int IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CNTMAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
   localparam int CNTW   = (CNTMAX > 1) ? $clog2(CNTMAX) : 1;

   localparam logic [0:0] ST_GAP  = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;

   localparam logic [CNTW-1:0] SHOW_LAST = CNTW'(REFRESH_DIV - 1);
   localparam logic [CNTW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNTW'(GAP_CYC - 1) : '0;
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);
   localparam logic [6:0]      SEG_OFF   = 7'h7F;

   logic [0:0]        state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [4*NDIG-1:0] bcd_q;
   logic [NDIG-1:0]   dpm_q;
   logic              wrap_pend_q, wrap_pend_d;
   logic [NDIG-1:0]   an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              tick_q, tick_d;

   logic              enter_show;
   logic              leave_show;
   logic              wrap;
   logic [3:0]        digit;
   logic [NDIG-1:0]   blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // Scan sequencer: SHOW holds a digit for REFRESH_DIV cycles, GAP darkens all anodes between digits.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      enter_show = 1'b0;
      leave_show = 1'b0;
      if (state_q == ST_SHOW) begin
         if (cnt_q == SHOW_LAST) begin
            leave_show = 1'b1;
            cnt_d      = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
            if (GAP_CYC == 0) begin
               state_d    = ST_SHOW;
               enter_show = 1'b1;
            end else begin
               state_d = ST_GAP;
            end
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end else begin
         if (GAP_CYC == 0 || cnt_q == GAP_LAST) begin
            state_d    = ST_SHOW;
            cnt_d      = '0;
            enter_show = 1'b1;
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end
   end

   // The wrap is remembered across the gap so the very first digit-0 entry after reset does not tick.
   assign wrap        = leave_show && (idx_q == IDX_LAST);
   assign tick_d      = enter_show && (idx_d == '0) && (wrap_pend_q || wrap);
   assign wrap_pend_d = enter_show ? 1'b0 : (wrap_pend_q || wrap);

`ifdef SEVSEG_LZB_EN
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NDIG - 1; i > 0; i--) begin
         zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0) && !dpm_q[i];
         blank[i] = zero_run;
      end
   end
`else
   assign blank = '0;
`endif

   assign digit = bcd_q[4*idx_d +: 4];

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == ST_SHOW && !blank[idx_d]) begin
         an_d  = ~(NDIG'(1) << idx_d);
         seg_d = seg_decode(digit);
         dp_d  = ~dpm_q[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_GAP;
         cnt_q       <= '0;
         idx_q       <= '0;
         bcd_q       <= '0;
         dpm_q       <= '0;
         wrap_pend_q <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wrap_pend_q <= wrap_pend_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         tick_q      <= tick_d;
         if (load) begin
            bcd_q <= bcd;
            dpm_q <= dp_mask;
         end
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;

endmodule
